// File: rtl/vga_timing_pkg.sv
// Shared vertical/horizontal timing types: phase enum, phase-order codes, counter width helper.
package vga_timing_pkg;

   typedef enum logic [1:0] {
      PH_ACTIVE,
      PH_BACK,
      PH_SYNC,
      PH_FRONT
   } phase_t;

   localparam logic ORDER_SYNC_LAST  = 1'b0;
   localparam logic ORDER_SYNC_FIRST = 1'b1;

   // Four phases of up to 2^YRES-1 lines each fit in two extra bits.
   localparam int TOTAL_EXTRA_BITS = 2;

   function automatic int total_width(input int yres);
      return yres + TOTAL_EXTRA_BITS;
   endfunction

endpackage

// File: rtl/line_end_falling_oneshot.sv
// Registered falling-edge detector: pulse is high for one cycle after level is sampled 1->0.
// Latency 1 cycle; no backpressure. Reset clears history so an edge during reset is lost.
module line_end_falling_oneshot (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic level_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         level_q <= 1'b0;
         pulse   <= 1'b0;
      end else begin
         level_q <= level;
         pulse   <= level_q & ~level;
      end
   end

endmodule

// File: rtl/vsync_timing_gen.sv
// Vertical timing generator: line counter with frame-shadowed phase lengths and selectable order.
// LineEnd fall at n -> outputs at n+2; no backpressure. Optional frame_count via VSYNC_FRAME_COUNT_EN.
module vsync_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int YRES             = 10,
   parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            LineEnd,
   input  logic [YRES-1:0] ActiveVideo,
   input  logic [YRES-1:0] BackPorch,
   input  logic [YRES-1:0] SynchPulse,
   input  logic [YRES-1:0] FrontPorch,
   input  logic            sync_first,
   output logic            vsync,
   output logic [YRES-1:0] yposition,
   output logic            video_on,
   output logic            frame_start
`ifdef VSYNC_FRAME_COUNT_EN
   ,
   output logic [15:0]     frame_count
`endif
);

   localparam int   TW      = total_width(YRES);
   localparam logic VS_IDLE = !SYNC_ACTIVE_HIGH;

   logic            line_adv;
   logic [YRES-1:0] a_q, b_q, s_q, f_q;
   logic            order_q;
   logic [TW-1:0]   a_w, b_w, s_w, f_w;
   logic [TW-1:0]   total;
   logic [TW-1:0]   ycount;
   logic            total_zero;
   logic            wrap;
   logic            wrap_q;
   logic            resample;
   logic [TW-1:0]   act_lo, back_lo, sync_lo;
   phase_t          phase;

   line_end_falling_oneshot u_line_end (
      .clock (clock),
      .reset (reset),
      .level (LineEnd),
      .pulse (line_adv)
   );

   assign a_w        = TW'(a_q);
   assign b_w        = TW'(b_q);
   assign s_w        = TW'(s_q);
   assign f_w        = TW'(f_q);
   assign total      = a_w + b_w + s_w + f_w;
   assign total_zero = (total == '0);
   assign wrap       = line_adv && !total_zero && (ycount == total - TW'(1));
   // A zero-length frame keeps tracking the inputs so it can restart as soon as they become valid.
   assign resample   = reset || wrap || total_zero;

   always_ff @(posedge clock) begin
      if (resample) begin
         a_q     <= ActiveVideo;
         b_q     <= BackPorch;
         s_q     <= SynchPulse;
         f_q     <= FrontPorch;
         order_q <= sync_first;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ycount <= '0;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap;
         if (total_zero || wrap) begin
            ycount <= '0;
         end else if (line_adv) begin
            ycount <= ycount + TW'(1);
         end
      end
   end

   function automatic logic in_range(input logic [TW-1:0] v,
                                     input logic [TW-1:0] lo,
                                     input logic [TW-1:0] len);
      return (v >= lo) && (v < lo + len);
   endfunction

   always_comb begin
      act_lo  = '0;
      back_lo = a_w;
      sync_lo = a_w + b_w;
      if (order_q == ORDER_SYNC_FIRST) begin
         sync_lo = '0;
         back_lo = s_w;
         act_lo  = s_w + b_w;
      end
      // Empty ranges never match, so zero-length phases fall through naturally.
      phase = PH_FRONT;
      if (in_range(ycount, act_lo, a_w)) begin
         phase = PH_ACTIVE;
      end else if (in_range(ycount, back_lo, b_w)) begin
         phase = PH_BACK;
      end else if (in_range(ycount, sync_lo, s_w)) begin
         phase = PH_SYNC;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vsync       <= VS_IDLE;
         yposition   <= '0;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vsync       <= (phase == PH_SYNC) ? !VS_IDLE : VS_IDLE;
         video_on    <= (phase == PH_ACTIVE);
         yposition   <= (phase == PH_ACTIVE) ? YRES'(ycount - act_lo) : '0;
         frame_start <= wrap_q;
      end
   end

`ifdef VSYNC_FRAME_COUNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_count <= '0;
      end else if (wrap_q) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule
